inc_dec_by_value: RTL and testbench

Parametrised successor to the 8-bit increment-by-value counter. Counts up or down by a per-cycle step value, supports parallel load, and offers wrap or saturate arithmetic. Provides sticky overflow/underflow flags and a registered threshold-crossing pulse. Used as the general event/credit counter in datapath and test infrastructure.

---
 rtl/inc_dec_pkg.sv | 26 ++
 rtl/inc_dec_step.sv | 65 ++++++
 rtl/inc_dec_by_value.sv | 94 +++++++++
 tb/tb_inc_dec_by_value.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inc_dec_pkg.sv
// Shared types and the operation decode for the inc_dec_by_value counter.
// Build option: INC_DEC_BY_VALUE_SAT_EN enables saturating arithmetic.
package inc_dec_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  // Load beats counting; conflicting inc/dec requests cancel to a hold.
  function automatic op_e decode_op(input logic load, input logic inc, input logic dec);
    op_e op;
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (inc && !dec) begin
      op = OP_INC;
    end else if (dec && !inc) begin
      op = OP_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/inc_dec_step.sv
// Combinational next-count datapath: widened add/subtract with carry/borrow
// detection; saturation is present only when INC_DEC_BY_VALUE_SAT_EN is defined.
module inc_dec_step
  import inc_dec_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned VAL_W = 3
) (
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] cnt,
  input  logic [VAL_W-1:0] val,
  input  logic [CNT_W-1:0] load_val,
  input  logic             sat_mode,
  output logic [CNT_W-1:0] next_cnt_c,
  output logic             carry_c,
  output logic             borrow_c
);

  localparam int unsigned EXT_W = CNT_W + 1;

  logic [EXT_W-1:0] cnt_ext;
  logic [EXT_W-1:0] val_ext;
  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] diff;

  // One extra bit captures the carry out of the add and the borrow of the subtract.
  assign cnt_ext = EXT_W'(cnt);
  assign val_ext = EXT_W'(val);
  assign sum     = cnt_ext + val_ext;
  assign diff    = cnt_ext - val_ext;

`ifndef INC_DEC_BY_VALUE_SAT_EN
  logic unused_sat_mode;
  assign unused_sat_mode = sat_mode;
`endif

  always_comb begin
    next_cnt_c = cnt;
    carry_c    = 1'b0;
    borrow_c   = 1'b0;
    case (op_e'(op))
      OP_INC: begin
        carry_c    = sum[CNT_W];
        next_cnt_c = sum[CNT_W-1:0];
`ifdef INC_DEC_BY_VALUE_SAT_EN
        if (sum[CNT_W] && sat_mode) begin
          next_cnt_c = '1;
        end
`endif
      end
      OP_DEC: begin
        borrow_c   = diff[CNT_W];
        next_cnt_c = diff[CNT_W-1:0];
`ifdef INC_DEC_BY_VALUE_SAT_EN
        if (diff[CNT_W] && sat_mode) begin
          next_cnt_c = '0;
        end
`endif
      end
      OP_LOAD: next_cnt_c = load_val;
      default: next_cnt_c = cnt;
    endcase
  end

endmodule

// File: rtl/inc_dec_by_value.sv
// Up/down counter stepping by a per-cycle value with load, sticky ovf/unf flags
// and a registered threshold-crossing pulse. Option: INC_DEC_BY_VALUE_SAT_EN.
module inc_dec_by_value
  import inc_dec_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned VAL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic [VAL_W-1:0] val,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             sat_mode,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf,
  output logic             hit
);

  if (CNT_W < 2 || VAL_W < 1 || VAL_W > CNT_W) begin : g_bad_params
    $error("inc_dec_by_value: need CNT_W >= 2 and 1 <= VAL_W <= CNT_W");
  end

  op_e              op_c;
  logic [CNT_W-1:0] next_cnt_c;
  logic             carry_c;
  logic             borrow_c;
  logic             cross_c;
  logic             cross_q;

  assign op_c = decode_op(load, inc, dec);

  inc_dec_step #(
    .CNT_W (CNT_W),
    .VAL_W (VAL_W)
  ) u_step (
    .op         (op_c),
    .cnt        (cnt),
    .val        (val),
    .load_val   (load_val),
    .sat_mode   (sat_mode),
    .next_cnt_c (next_cnt_c),
    .carry_c    (carry_c),
    .borrow_c   (borrow_c)
  );

  // Upward crossing between the current and the about-to-be-written count.
  assign cross_c = (cnt < thresh) && (next_cnt_c >= thresh);

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= next_cnt_c;
    end
  end

  // Sticky flags; a fresh event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (carry_c) begin
        ovf <= 1'b1;
      end else if (clr_flags) begin
        ovf <= 1'b0;
      end
      if (borrow_c) begin
        unf <= 1'b1;
      end else if (clr_flags) begin
        unf <= 1'b0;
      end
    end
  end

  // Crossing is captured with the count update and surfaces one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cross_q <= 1'b0;
      hit     <= 1'b0;
    end else begin
      cross_q <= cross_c;
      hit     <= cross_q;
    end
  end

endmodule

// File: tb/tb_inc_dec_by_value.sv
// Directed self-checking bench for inc_dec_by_value (CNT_W=8, VAL_W=3).
module tb_inc_dec_by_value;

`ifdef INC_DEC_BY_VALUE_SAT_EN
  localparam bit SAT_BUILT = 1'b1;
`else
  localparam bit SAT_BUILT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       inc;
  logic       dec;
  logic [2:0] val;
  logic       load;
  logic [7:0] load_val;
  logic       sat_mode;
  logic [7:0] thresh;
  logic       clr_flags;
  logic [7:0] cnt;
  logic       ovf;
  logic       unf;
  logic       hit;

  int vectors;
  int miscompares;

  inc_dec_by_value #(.CNT_W(8), .VAL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .dec       (dec),
    .val       (val),
    .load      (load),
    .load_val  (load_val),
    .sat_mode  (sat_mode),
    .thresh    (thresh),
    .clr_flags (clr_flags),
    .cnt       (cnt),
    .ovf       (ovf),
    .unf       (unf),
    .hit       (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_cnt, input logic e_ovf,
                         input logic e_unf, input logic e_hit);
    chk({tag, ".cnt"}, cnt, e_cnt);
    chk({tag, ".ovf"}, 8'(ovf), 8'(e_ovf));
    chk({tag, ".unf"}, 8'(unf), 8'(e_unf));
    chk({tag, ".hit"}, 8'(hit), 8'(e_hit));
  endtask

  task automatic drv(input logic i, input logic d, input logic [2:0] v, input logic l,
                     input logic [7:0] lv, input logic c);
    inc = i; dec = d; val = v; load = l; load_val = lv; clr_flags = c;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0);
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] lv);
    drv(1'b0, 1'b0, 3'd0, 1'b1, lv, 1'b0);
    tick();
    idle();
  endtask

  task automatic do_inc(input logic [2:0] v);
    drv(1'b1, 1'b0, v, 1'b0, 8'd0, 1'b0);
    tick();
    idle();
  endtask

  task automatic do_dec(input logic [2:0] v);
    drv(1'b0, 1'b1, v, 1'b0, 8'd0, 1'b0);
    tick();
    idle();
  endtask

  task automatic do_clr();
    drv(1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b1);
    tick();
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    sat_mode = 1'b0;
    thresh = 8'd200;
    idle();

    repeat (2) @(negedge clk);
    chk_all("in_reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    chk_all("idle3", 8'd0, 1'b0, 1'b0, 1'b0);

    // Step increments 3..7 with idle gaps, then a decrement.
    do_inc(3'd3); chk("inc3", cnt, 8'd3);  tick();
    do_inc(3'd4); chk("inc4", cnt, 8'd7);  tick();
    do_inc(3'd5); chk("inc5", cnt, 8'd12); tick();
    do_inc(3'd6); chk("inc6", cnt, 8'd18); tick();
    do_inc(3'd7); chk("inc7", cnt, 8'd25); tick();
    chk("idle_hold", cnt, 8'd25);
    do_dec(3'd5); chk("dec5", cnt, 8'd20);

    // Asynchronous reset mid-count with a crossing still in flight.
    thresh = 8'd30;
    do_load(8'd37);
    chk_all("load37", 8'd37, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1 chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    thresh = 8'd200;
    tick();
    chk_all("post_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_hit", 8'(hit), 8'd0);

    // Exact top is not overflow; overflow in wrap, then clear.
    do_load(8'd248);
    do_inc(3'd7);
    chk("reach_max.cnt", cnt, 8'd255);
    chk("reach_max.ovf", 8'(ovf), 8'd0);
    do_load(8'd250);
    sat_mode = 1'b0;
    do_inc(3'd7);
    chk("ovf_wrap.cnt", cnt, 8'd1);
    chk("ovf_wrap.ovf", 8'(ovf), 8'd1);
    do_load(8'd100);
    chk("load_keeps_ovf", 8'(ovf), 8'd1);
    do_clr();
    chk("clr_ovf", 8'(ovf), 8'd0);
    do_load(8'd250);
    sat_mode = 1'b1;
    do_inc(3'd7);
    chk("ovf_sat.cnt", cnt, SAT_BUILT ? 8'd255 : 8'd1);
    chk("ovf_sat.ovf", 8'(ovf), 8'd1);
    sat_mode = 1'b0;
    do_clr();

    // Underflow in wrap and saturate; exact zero is not underflow.
    do_load(8'd2);
    do_dec(3'd5);
    chk("unf_wrap.cnt", cnt, 8'd253);
    chk("unf_wrap.unf", 8'(unf), 8'd1);
    do_clr();
    chk("clr_unf", 8'(unf), 8'd0);
    do_load(8'd5);
    do_dec(3'd5);
    chk("reach_zero.cnt", cnt, 8'd0);
    chk("reach_zero.unf", 8'(unf), 8'd0);
    do_load(8'd2);
    sat_mode = 1'b1;
    do_dec(3'd5);
    chk("unf_sat.cnt", cnt, SAT_BUILT ? 8'd0 : 8'd253);
    chk("unf_sat.unf", 8'(unf), 8'd1);
    do_clr();
    chk("clr_unf2", 8'(unf), 8'd0);
    do_load(8'd2);
    drv(1'b0, 1'b1, 3'd5, 1'b0, 8'd0, 1'b1);
    tick();
    idle();
    chk("set_wins.cnt", cnt, SAT_BUILT ? 8'd0 : 8'd253);
    chk("set_wins.unf", 8'(unf), 8'd1);
    sat_mode = 1'b0;
    do_clr();

    // Hold and priority cases.
    do_load(8'd100);
    drv(1'b1, 1'b1, 3'd4, 1'b0, 8'd0, 1'b0);
    tick();
    idle();
    chk("inc_and_dec", cnt, 8'd100);
    drv(1'b1, 1'b0, 3'd7, 1'b1, 8'd60, 1'b0);
    tick();
    idle();
    chk("load_over_inc", cnt, 8'd60);
    do_inc(3'd0);
    chk_all("inc_val0", 8'd60, 1'b0, 1'b0, 1'b0);
    do_dec(3'd0);
    chk_all("dec_val0", 8'd60, 1'b0, 1'b0, 1'b0);

    // Threshold crossing pulse.
    thresh = 8'd10;
    do_load(8'd8);
    tick();
    chk("pre_cross", cnt, 8'd8);
    do_inc(3'd3);
    chk("cross.cnt", cnt, 8'd11);
    chk("cross.hit_early", 8'(hit), 8'd0);
    tick();
    chk("cross.hit", 8'(hit), 8'd1);
    tick();
    chk("cross.hit_one_cycle", 8'(hit), 8'd0);
    do_inc(3'd3);
    chk("above.cnt", cnt, 8'd14);
    tick();
    chk("above.hit", 8'(hit), 8'd0);
    do_load(8'd255);
    tick();
    do_inc(3'd3);
    chk("wrap.cnt", cnt, 8'd2);
    chk("wrap.ovf", 8'(ovf), 8'd1);
    tick();
    chk("wrap.hit", 8'(hit), 8'd0);
    do_load(8'd0);
    tick();
    do_load(8'd12);
    chk("load_cross.cnt", cnt, 8'd12);
    chk("load_cross.hit_early", 8'(hit), 8'd0);
    tick();
    chk("load_cross.hit", 8'(hit), 8'd1);
    tick();
    chk("load_cross.hit_off", 8'(hit), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
